rom: RTL and testbench

ROM -- requirements
Module: rom

---
 rtl/rom_pkg.sv | 29 ++
 rtl/rom.sv | 56 +++++
 tb/tb_rom.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rom_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_pkg
//  Description : Shared constants for the 16 x 8 program ROM of the model
//                computer. Holds the default geometry and the fixed content
//                table, so the ROM, the computer top level and benches agree.
//  Revision    : 1.0 - initial release
// ============================================================================
package rom_pkg;

   localparam int ROM_ADDR_W = 4;
   localparam int ROM_DATA_W = 8;
   localparam int ROM_DEPTH  = 1 << ROM_ADDR_W;

   // Program: LDA 9, ADD A, ADD B, SUB C, OUT, HLT; data 16, 20, 24, 32.
   localparam logic [ROM_DATA_W-1:0] ROM_TABLE [0:ROM_DEPTH-1] = '{
      8'h09, 8'h1A, 8'h1B, 8'h2C,
      8'hE0, 8'hF0, 8'h00, 8'h00,
      8'h00, 8'h10, 8'h14, 8'h18,
      8'h20, 8'h00, 8'h00, 8'h00
   };

   // Word lookup into the fixed content table.
   function automatic logic [ROM_DATA_W-1:0] rom_word(input logic [ROM_ADDR_W-1:0] addr);
      return ROM_TABLE[addr];
   endfunction

endpackage : rom_pkg
`default_nettype wire

// File: rtl/rom.sv
`default_nettype none
// ============================================================================
//  Module      : rom
//  Description : 16 x 8 read-only memory with registered output and a
//                tri-state data bus. One-clock read latency, active-low chip
//                enable; DBUS floats whenever the output is not enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom
   import rom_pkg::*;
#(
   parameter int ADDR_W = ROM_ADDR_W,
   parameter int DATA_W = ROM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              CE,
   input  logic [ADDR_W-1:0] ABUS,
   output tri   [DATA_W-1:0] DBUS
);

   logic [DATA_W-1:0] lookup;
   logic [DATA_W-1:0] data_reg;
   logic              oe_reg;

   // Combinational content lookup of the presented address.
   always_comb begin
      lookup = DATA_W'(rom_word(ROM_ADDR_W'(ABUS)));
   end

   // Output data register: captures the addressed word while selected,
   // holds while deselected, clears on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_reg <= '0;
      end else if (CE == 1'b0) begin
         data_reg <= lookup;
      end
   end

   // Output-enable register: an unknown CE fails the equality test and
   // therefore falls into the deselected branch.
   always_ff @(posedge clk) begin
      if (rst) begin
         oe_reg <= 1'b0;
      end else if (CE == 1'b0) begin
         oe_reg <= 1'b1;
      end else begin
         oe_reg <= 1'b0;
      end
   end

   assign DBUS = oe_reg ? data_reg : {DATA_W{1'bz}};

endmodule : rom
`default_nettype wire

// File: tb/tb_rom.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom
//  Description : Directed self-checking bench for rom. Two instances share
//                the stimulus; one bus is pulled up and one pulled down, so a
//                floating bus reads FF on one and 00 on the other.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom;

   localparam logic [8:0] HIZ = 9'h100;   // observed-value code for high-Z
   localparam logic [8:0] BAD = 9'h1FF;   // partially driven bus

   logic       clk;
   logic       rst;
   logic       CE;
   logic [3:0] ABUS;
   tri1  [7:0] dbus_pu;
   tri0  [7:0] dbus_pd;

   int vectors;
   int miscompares;

   // Hand-entered expected contents, independent of the package table.
   logic [7:0] exp_mem [0:15];

   rom u_dut_pu (
      .clk  (clk),
      .rst  (rst),
      .CE   (CE),
      .ABUS (ABUS),
      .DBUS (dbus_pu)
   );

   rom u_dut_pd (
      .clk  (clk),
      .rst  (rst),
      .CE   (CE),
      .ABUS (ABUS),
      .DBUS (dbus_pd)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [8:0] observe();
      if (dbus_pu == 8'hFF && dbus_pd == 8'h00) return HIZ;
      if (dbus_pu == dbus_pd)                   return {1'b0, dbus_pu};
      return BAD;
   endfunction

   task automatic check_val(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %03h expected %03h (100 = high-Z)", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      exp_mem[0]  = 8'h09; exp_mem[1]  = 8'h1A; exp_mem[2]  = 8'h1B; exp_mem[3]  = 8'h2C;
      exp_mem[4]  = 8'hE0; exp_mem[5]  = 8'hF0; exp_mem[6]  = 8'h00; exp_mem[7]  = 8'h00;
      exp_mem[8]  = 8'h00; exp_mem[9]  = 8'h10; exp_mem[10] = 8'h14; exp_mem[11] = 8'h18;
      exp_mem[12] = 8'h20; exp_mem[13] = 8'h00; exp_mem[14] = 8'h00; exp_mem[15] = 8'h00;

      // Reset with the chip selected: bus must float.
      rst = 1'b1; CE = 1'b0; ABUS = 4'h3;
      tick();
      check_val("reset_hiz", observe(), HIZ);
      tick();
      check_val("reset_hold_hiz", observe(), HIZ);
      rst = 1'b0;
      tick();
      check_val("post_reset_rd3", observe(), 9'h02C);

      // Full address sweep, one new address per clock.
      for (int a = 0; a < 16; a++) begin
         ABUS = 4'(a);
         tick();
         check_val($sformatf("sweep_%0h", a), observe(), {1'b0, exp_mem[a]});
      end

      // Deselect / reselect.
      ABUS = 4'h4;
      tick();
      check_val("desel_rd4", observe(), 9'h0E0);
      CE = 1'b1;
      tick();
      check_val("desel_hiz", observe(), HIZ);
      CE = 1'b0; ABUS = 4'h5;
      tick();
      check_val("resel_rd5", observe(), 9'h0F0);

      // Address toggling while deselected.
      CE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ABUS = (i % 2 == 0) ? 4'h9 : 4'hA;
         tick();
         check_val($sformatf("desel_toggle_%0d", i), observe(), HIZ);
      end

      // Reset in the middle of a read stream.
      CE = 1'b0; ABUS = 4'h9;
      tick();
      check_val("stream_rd9", observe(), 9'h010);
      ABUS = 4'hA;
      tick();
      check_val("stream_rdA", observe(), 9'h014);
      ABUS = 4'hB; rst = 1'b1;
      tick();
      check_val("stream_rst_hiz", observe(), HIZ);
      rst = 1'b0; CE = 1'b1;
      tick();
      check_val("after_rst_desel_hiz", observe(), HIZ);

      // Latency: new address between edges must not disturb the bus.
      CE = 1'b0; ABUS = 4'h1;
      tick();
      check_val("lat_rd1", observe(), 9'h01A);
      ABUS = 4'h2;
      #3;
      check_val("lat_rd1_stable", observe(), 9'h01A);
      tick();
      check_val("lat_rd2", observe(), 9'h01B);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_rom
`default_nettype wire
